// File: rtl/cp2_task_table_pkg.sv
// Shared definitions for the cp2 task control table: op codes, info selectors,
// trigger classes and the wrap-safe release-time compare.
package cp2_task_table_pkg;

  localparam logic [1:0] AORD_ADD = 2'b01;
  localparam logic [1:0] AORD_DEL = 2'b10;

  typedef enum logic [2:0] {
    TASKINFO_STATUS   = 3'd0,
    TASKINFO_CYCLE    = 3'd1,
    TASKINFO_PHASE    = 3'd2,
    TASKINFO_DEADLINE = 3'd3,
    TASKINFO_NEXTREL  = 3'd4,
    TASKNOSEL         = 3'd7
  } task_info_sel_e;

  localparam logic TRIG_TT = 1'b1;
  localparam logic TRIG_ET = 1'b0;

  // Due when (now - due_time) is non-negative as a signed value, so 32-bit time wrap is tolerated.
  function automatic logic time_due(input logic [31:0] now, input logic [31:0] due_time);
    logic [31:0] diff;
    diff = now - due_time;
    return ~diff[31];
  endfunction

endpackage

// File: rtl/cp2_task_table_scan.sv
// Sequential task scanner: walks one entry per cycle, releases due TT tasks and
// publishes the lowest-index ready task per class at the end of each sweep.
module cp2_task_table_scan
  import cp2_task_table_pkg::*;
#(
  parameter int unsigned TASK_AW = 6,
  parameter int unsigned N_TASKS = 2**TASK_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        g_time_l,
  input  logic               ent_valid,
  input  logic               ent_ready,
  input  logic               ent_trig,
  input  logic               ent_cyen,
  input  logic [31:0]        ent_cycle,
  input  logic [31:0]        ent_next_rel,
  output logic [TASK_AW-1:0] scan_ptr,
  output logic               rel_stb,
  output logic [31:0]        rel_next,
  output logic [TASK_AW:0]   tt_top_pri_task,
  output logic [TASK_AW:0]   et_top_pri_task
);

  localparam logic [TASK_AW-1:0] LAST_IDX = TASK_AW'(N_TASKS - 1);

  logic               tt_c_found;
  logic               et_c_found;
  logic [TASK_AW-1:0] tt_c_idx;
  logic [TASK_AW-1:0] et_c_idx;
  logic               ent_rdy;
  logic               tt_hit;
  logic               et_hit;

  always_comb begin
    rel_stb  = ent_valid & (ent_trig == TRIG_TT) & ent_cyen & time_due(g_time_l, ent_next_rel);
    rel_next = ent_next_rel + ent_cycle;
    // Candidate uses stored state plus this cycle's release, never a same-cycle CPU write.
    ent_rdy  = ent_valid & (ent_ready | rel_stb);
    tt_hit   = ent_rdy & (ent_trig == TRIG_TT) & ~tt_c_found;
    et_hit   = ent_rdy & (ent_trig == TRIG_ET) & ~et_c_found;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_ptr        <= '0;
      tt_c_found      <= 1'b0;
      et_c_found      <= 1'b0;
      tt_c_idx        <= '0;
      et_c_idx        <= '0;
      tt_top_pri_task <= '0;
      et_top_pri_task <= '0;
    end else begin
      scan_ptr <= scan_ptr + 1'b1;
      if (scan_ptr == LAST_IDX) begin
        tt_top_pri_task <= tt_c_found ? {1'b1, tt_c_idx} : (tt_hit ? {1'b1, scan_ptr} : '0);
        et_top_pri_task <= et_c_found ? {1'b1, et_c_idx} : (et_hit ? {1'b1, scan_ptr} : '0);
        tt_c_found      <= 1'b0;
        et_c_found      <= 1'b0;
        tt_c_idx        <= '0;
        et_c_idx        <= '0;
      end else begin
        if (tt_hit) begin
          tt_c_found <= 1'b1;
          tt_c_idx   <= scan_ptr;
        end
        if (et_hit) begin
          et_c_found <= 1'b1;
          et_c_idx   <= scan_ptr;
        end
      end
    end
  end

endmodule

// File: rtl/cp2_task_table.sv
// Task control table downstream of cp2_ctrl: per-task storage, CPU write logic
// and field readback; release/priority selection lives in cp2_task_table_scan.
module cp2_task_table
  import cp2_task_table_pkg::*;
#(
  parameter int unsigned TASK_AW = 6,
  parameter int unsigned N_TASKS = 2**TASK_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        g_time_l,
  input  logic [TASK_AW-1:0] task_sel,
  input  logic [TASK_AW-1:0] task_sel_r,
  input  logic               task_chs_ena,
  input  logic               task_new_status,
  input  logic [1:0]         task_aord_op,
  input  logic               task_chcy_ena,
  input  logic               task_chph_ena,
  input  logic               task_chdeadline_ena,
  input  logic               task_chcyen_ena,
  input  logic               task_cyen_op,
  input  logic [31:0]        task_write_data_input,
  input  logic               task_trigger_op_ena,
  input  logic               task_trigger_op,
  input  logic [2:0]         task_info_sel,
  output logic [31:0]        task_info,
  output logic [TASK_AW:0]   tt_top_pri_task,
  output logic [TASK_AW:0]   et_top_pri_task
);

  logic [N_TASKS-1:0] valid_q;
  logic [N_TASKS-1:0] ready_q;
  logic [N_TASKS-1:0] trig_q;
  logic [N_TASKS-1:0] cyen_q;
  logic [31:0]        cycle_q    [N_TASKS];
  logic [31:0]        phase_q    [N_TASKS];
  logic [31:0]        deadline_q [N_TASKS];
  logic [31:0]        next_rel_q [N_TASKS];

  logic [TASK_AW-1:0] scan_ptr;
  logic               rel_stb;
  logic [31:0]        rel_next;
  logic               op_add;
  logic               op_del;

  assign op_add = (task_aord_op == AORD_ADD);
  assign op_del = (task_aord_op == AORD_DEL);

  cp2_task_table_scan #(
    .TASK_AW (TASK_AW),
    .N_TASKS (N_TASKS)
  ) u_scan (
    .clk             (clk),
    .rst             (rst),
    .g_time_l        (g_time_l),
    .ent_valid       (valid_q[scan_ptr]),
    .ent_ready       (ready_q[scan_ptr]),
    .ent_trig        (trig_q[scan_ptr]),
    .ent_cyen        (cyen_q[scan_ptr]),
    .ent_cycle       (cycle_q[scan_ptr]),
    .ent_next_rel    (next_rel_q[scan_ptr]),
    .scan_ptr        (scan_ptr),
    .rel_stb         (rel_stb),
    .rel_next        (rel_next),
    .tt_top_pri_task (tt_top_pri_task),
    .et_top_pri_task (et_top_pri_task)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      ready_q <= '0;
      trig_q  <= '0;
      cyen_q  <= '0;
      for (int unsigned i = 0; i < N_TASKS; i++) begin
        cycle_q[i]    <= '0;
        phase_q[i]    <= '0;
        deadline_q[i] <= '0;
        next_rel_q[i] <= '0;
      end
    end else begin
      // Scanner update first; any CPU write to the same field below takes precedence.
      if (rel_stb) begin
        ready_q[scan_ptr]    <= 1'b1;
        next_rel_q[scan_ptr] <= rel_next;
      end
      if (op_del) begin
        valid_q[task_sel] <= 1'b0;
        ready_q[task_sel] <= 1'b0;
        cyen_q[task_sel]  <= 1'b0;
      end else begin
        if (op_add) begin
          valid_q[task_sel] <= 1'b1;
          ready_q[task_sel] <= 1'b0;
          cyen_q[task_sel]  <= 1'b0;
        end
        if (task_chs_ena && (valid_q[task_sel] || op_add))
          ready_q[task_sel] <= task_new_status;
        if (task_chcyen_ena) begin
          cyen_q[task_sel] <= task_cyen_op;
          if (task_cyen_op)
            next_rel_q[task_sel] <= g_time_l + phase_q[task_sel];
        end
      end
      if (task_chcy_ena)       cycle_q[task_sel]    <= task_write_data_input;
      if (task_chph_ena)       phase_q[task_sel]    <= task_write_data_input;
      if (task_chdeadline_ena) deadline_q[task_sel] <= task_write_data_input;
      if (task_trigger_op_ena) trig_q[task_sel]     <= task_trigger_op;
    end
  end

  always_comb begin
    task_info = '0;
    case (task_info_sel)
      TASKINFO_STATUS:   task_info = {28'b0, valid_q[task_sel_r], ready_q[task_sel_r],
                                      trig_q[task_sel_r], cyen_q[task_sel_r]};
      TASKINFO_CYCLE:    task_info = cycle_q[task_sel_r];
      TASKINFO_PHASE:    task_info = phase_q[task_sel_r];
      TASKINFO_DEADLINE: task_info = deadline_q[task_sel_r];
      TASKINFO_NEXTREL:  task_info = next_rel_q[task_sel_r];
      default:           task_info = '0;
    endcase
  end

endmodule

// File: tb/tb_cp2_task_table.sv
// Directed self-checking bench for cp2_task_table: reset, add/delete priority,
// TT release, time wrap, CPU/scanner collisions and mid-sweep async reset.
module tb_cp2_task_table;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] g_time_l;
  logic [5:0]  task_sel;
  logic [5:0]  task_sel_r;
  logic        task_chs_ena;
  logic        task_new_status;
  logic [1:0]  task_aord_op;
  logic        task_chcy_ena;
  logic        task_chph_ena;
  logic        task_chdeadline_ena;
  logic        task_chcyen_ena;
  logic        task_cyen_op;
  logic [31:0] task_write_data_input;
  logic        task_trigger_op_ena;
  logic        task_trigger_op;
  logic [2:0]  task_info_sel;
  logic [31:0] task_info;
  logic [6:0]  tt_top_pri_task;
  logic [6:0]  et_top_pri_task;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [5:0]  tb_ptr;

  always #5 clk = ~clk;

  cp2_task_table #(
    .TASK_AW (6),
    .N_TASKS (64)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .g_time_l              (g_time_l),
    .task_sel              (task_sel),
    .task_sel_r            (task_sel_r),
    .task_chs_ena          (task_chs_ena),
    .task_new_status       (task_new_status),
    .task_aord_op          (task_aord_op),
    .task_chcy_ena         (task_chcy_ena),
    .task_chph_ena         (task_chph_ena),
    .task_chdeadline_ena   (task_chdeadline_ena),
    .task_chcyen_ena       (task_chcyen_ena),
    .task_cyen_op          (task_cyen_op),
    .task_write_data_input (task_write_data_input),
    .task_trigger_op_ena   (task_trigger_op_ena),
    .task_trigger_op       (task_trigger_op),
    .task_info_sel         (task_info_sel),
    .task_info             (task_info),
    .tt_top_pri_task       (tt_top_pri_task),
    .et_top_pri_task       (et_top_pri_task)
  );

  // Expected sweep position: entry the scanner handles at the next posedge.
  always @(posedge clk or negedge rst)
    if (!rst) tb_ptr <= '0;
    else      tb_ptr <= tb_ptr + 6'd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    task_chs_ena = 0; task_new_status = 0; task_aord_op = 2'b00;
    task_chcy_ena = 0; task_chph_ena = 0; task_chdeadline_ena = 0;
    task_chcyen_ena = 0; task_cyen_op = 0; task_write_data_input = '0;
    task_trigger_op_ena = 0; task_trigger_op = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_ptr(input logic [5:0] t);
    int unsigned n = 0;
    while (tb_ptr !== t && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (tb_ptr !== t) begin
      n_err++;
      $error("FAIL wait_ptr observed=%h expected=%h", tb_ptr, t);
    end
  endtask

  task automatic info(input logic [5:0] idx, input logic [2:0] sel, input string tag,
                      input logic [31:0] exp);
    task_sel_r = idx; task_info_sel = sel; #1;
    check(tag, task_info, exp);
  endtask

  initial begin
    rst = 1'b0;
    g_time_l = '0; task_sel = '0; task_sel_r = '0; task_info_sel = '0;
    idle();
    wait_cycles(3);
    check("rst_tt", {25'b0, tt_top_pri_task}, 32'h0);
    check("rst_et", {25'b0, et_top_pri_task}, 32'h0);
    @(negedge clk); rst = 1'b1;
    wait_cycles(64);
    check("sweep0_tt", {25'b0, tt_top_pri_task}, 32'h0);
    check("sweep0_et", {25'b0, et_top_pri_task}, 32'h0);
    for (int s = 0; s < 8; s++) info(6'd0, 3'(s), "rst_info", 32'h0);

    // ET tasks 5 and 3 added ready; lower index wins
    task_sel = 6'd5; task_aord_op = 2'b01; task_chs_ena = 1; task_new_status = 1;
    task_trigger_op_ena = 1; task_trigger_op = 0; tick();
    task_sel = 6'd3; task_aord_op = 2'b01; task_chs_ena = 1; task_new_status = 1;
    task_trigger_op_ena = 1; task_trigger_op = 0; tick();
    wait_cycles(130);
    check("et_two", {25'b0, et_top_pri_task}, 32'h43);
    check("tt_none", {25'b0, tt_top_pri_task}, 32'h0);
    info(6'd5, 3'd0, "t5_status", 32'hC);
    task_sel = 6'd3; task_aord_op = 2'b10; tick();
    info(6'd3, 3'd0, "t3_deleted", 32'h0);
    wait_cycles(130);
    check("et_after_del", {25'b0, et_top_pri_task}, 32'h45);

    // TT task 9: cycle 100, phase 20, enabled at time 1000
    g_time_l = 32'd1000;
    task_sel = 6'd9; task_aord_op = 2'b01; task_trigger_op_ena = 1; task_trigger_op = 1;
    task_chcy_ena = 1; task_write_data_input = 32'd100; tick();
    task_sel = 6'd9; task_chph_ena = 1; task_write_data_input = 32'd20; tick();
    task_sel = 6'd9; task_chcyen_ena = 1; task_cyen_op = 1; tick();
    info(6'd9, 3'd4, "t9_nrel", 32'd1020);
    info(6'd9, 3'd1, "t9_cycle", 32'd100);
    info(6'd9, 3'd2, "t9_phase", 32'd20);
    info(6'd9, 3'd0, "t9_status", 32'hB);
    wait_cycles(130);
    check("t9_early_tt", {25'b0, tt_top_pri_task}, 32'h0);
    info(6'd9, 3'd0, "t9_not_rel", 32'hB);
    g_time_l = 32'd1020;
    wait_cycles(130);
    info(6'd9, 3'd0, "t9_rel_status", 32'hF);
    info(6'd9, 3'd4, "t9_rel_nrel", 32'd1120);
    check("t9_tt", {25'b0, tt_top_pri_task}, 32'h49);
    check("t9_et", {25'b0, et_top_pri_task}, 32'h45);

    // Wrap: next_release 0x10 while time is 0xFFFFFFF0
    g_time_l = 32'hFFFF_FFF0;
    task_sel = 6'd9; task_chs_ena = 1; task_new_status = 0; tick();
    task_sel = 6'd9; task_chph_ena = 1; task_write_data_input = 32'h20; tick();
    task_sel = 6'd9; task_chcyen_ena = 1; task_cyen_op = 1; tick();
    info(6'd9, 3'd4, "wrap_nrel", 32'h10);
    wait_cycles(130);
    info(6'd9, 3'd0, "wrap_hold_status", 32'hB);
    info(6'd9, 3'd4, "wrap_hold_nrel", 32'h10);
    check("wrap_hold_tt", {25'b0, tt_top_pri_task}, 32'h0);
    g_time_l = 32'h10;
    wait_cycles(130);
    info(6'd9, 3'd0, "wrap_rel_status", 32'hF);
    info(6'd9, 3'd4, "wrap_rel_nrel", 32'h74);
    check("wrap_rel_tt", {25'b0, tt_top_pri_task}, 32'h49);

    // Collision: chs=0 in the cycle the scanner releases task 9
    wait_ptr(6'd9);
    g_time_l = 32'h74;
    task_sel = 6'd9; task_chs_ena = 1; task_new_status = 0; tick();
    info(6'd9, 3'd0, "coll_chs_status", 32'hB);
    info(6'd9, 3'd4, "coll_chs_nrel", 32'hD8);
    wait_ptr(6'd0);
    check("coll_prewrite_tt", {25'b0, tt_top_pri_task}, 32'h49);
    wait_cycles(64);
    check("coll_next_tt", {25'b0, tt_top_pri_task}, 32'h0);

    // Collision: CPU next_release write beats the scanner's advance
    wait_ptr(6'd9);
    g_time_l = 32'hD8;
    task_sel = 6'd9; task_chcyen_ena = 1; task_cyen_op = 1; tick();
    info(6'd9, 3'd0, "coll_cyen_status", 32'hF);
    info(6'd9, 3'd4, "coll_cyen_nrel", 32'hF8);

    // Asynchronous reset mid-sweep
    wait_ptr(6'd0);
    check("pre_rst_tt", {25'b0, tt_top_pri_task}, 32'h49);
    check("pre_rst_et", {25'b0, et_top_pri_task}, 32'h45);
    wait_ptr(6'd30);
    #2 rst = 1'b0;
    #1;
    check("arst_tt", {25'b0, tt_top_pri_task}, 32'h0);
    check("arst_et", {25'b0, et_top_pri_task}, 32'h0);
    info(6'd5, 3'd0, "arst_t5", 32'h0);
    info(6'd9, 3'd4, "arst_t9_nrel", 32'h0);
    @(negedge clk); rst = 1'b1;
    task_sel = 6'd5; task_aord_op = 2'b01; task_chs_ena = 1; task_new_status = 1;
    task_trigger_op_ena = 1; task_trigger_op = 0; tick();
    wait_cycles(62);
    check("post_rst_nopub_et", {25'b0, et_top_pri_task}, 32'h0);
    wait_cycles(1);
    check("post_rst_pub_et", {25'b0, et_top_pri_task}, 32'h45);
    check("post_rst_pub_tt", {25'b0, tt_top_pri_task}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
